pipeline_latealu: RTL and testbench
===================================

PIPELINE_LATEALU -- requirements
Module: pipeline_latealu

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  synchronous, active-low reset; rst=0 at a posedge resets the block.
REQ-003 SHALL: req_valid  input  1  request strobe from ALU stage (latealu_enable).
REQ-004 SHALL: req_op  input  6  operation: 000010 srl, 000011 sra, 000100 mult, 000101 mthi, 000110 mtlo.
REQ-005 SHALL: req_a0  input  32  operand 0: shift source, multiplicand, or mthi/mtlo data.
REQ-006 SHALL: req_a1  input  32  operand 1: shift amount in bits [4:0], or multiplier.
REQ-007 SHALL: hilo_read  input  1  ALU stage is executing mfhi/mflo this cycle.
REQ-008 SHALL: flush  input  1  pipeline flush; aborts an in-progress mult.
REQ-009 SHALL: req_ready  output  1  high when a request can be accepted this cycle.
REQ-010 SHALL: stall  output  1  freezes pipeline stages at and before ALU.
REQ-011 SHALL: result_valid  output  1  one-cycle pulse marking a valid shift result.
REQ-012 SHALL: result_value  output  32  shift result.
REQ-013 SHALL: mult_hi, mult_lo  output  32 each  architectural HI/LO.
REQ-014 SHALL: busy  output  1  mult in progress.
REQ-015 SHALL: bad_op  output  1  one-cycle pulse when an unlisted op is requested.

Function
REQ-016 SHALL: implement FSM states IDLE, MULT, FIX; req_ready = (state==IDLE).
REQ-017 SHALL: accept a request when req_valid && req_ready at a posedge (acceptance edge E0).
REQ-018 SHALL: srl/sra execute in the acceptance cycle; result_value registered at E0, result_valid high for exactly the following cycle; state stays IDLE; back-to-back shifts are accepted every cycle.
REQ-019 SHALL: srl zero-fills and sra sign-fills; shift amount = req_a1[4:0]; amount 0 returns req_a0 unchanged.
REQ-020 SHALL: mthi/mtlo write mult_hi/mult_lo at E0; visible from the next cycle; state stays IDLE.
REQ-021 SHALL: mult is signed 32x32->64, computed as unsigned magnitudes with a radix-2 shift-add loop, one step per cycle, 6-bit step counter 0..31.
REQ-022 SHALL: mult transitions IDLE->MULT at E0; performs steps on edges E0+1..E0+32; enters FIX at E0+32; FIX negates the 64-bit product if operand signs differ and writes HI/LO at E0+33; returns to IDLE at E0+33.
REQ-023 SHALL: busy high from after E0 up to and including the cycle before E0+33; HI/LO keep their old values until E0+33.
REQ-024 SHALL: stall = (hilo_read && busy) || (req_valid && !req_ready).
REQ-025 SHALL: hilo_read while IDLE never stalls; a mthi/mtlo accepted at E0 is readable by hilo_read in the cycle after E0.
REQ-026 SHALL: flush while MULT or FIX returns to IDLE at that edge with HI/LO unchanged; flush takes precedence over a same-edge FIX write; a request presented with flush is not accepted.
REQ-027 SHALL: unlisted op with req_valid in IDLE is consumed, asserts bad_op for one cycle, changes no state.
REQ-028 SHALL: -2^31 operands handled correctly (magnitude held as 33-bit unsigned internally).
REQ-029 SHALL: result_valid and bad_op are low in every cycle not covered by REQ-018/REQ-027.

Reset
REQ-030 SHALL: on rst=0: state=IDLE, counter=0, mult_hi=0, mult_lo=0, result_value=0, result_valid=0, bad_op=0, busy=0.
REQ-031 SHALL: reset overrides flush and requests and aborts a mult mid-operation; req_ready=1 in the first cycle after reset release.

Verification
REQ-032 SHALL: srl then sra of a0=0x80000000, a1=4 on consecutive cycles -> result_value 0x08000000 then 0xF8000000, result_valid high two cycles, req_ready never low.
REQ-033 SHALL: mult a0=0xFFFFFFFD (-3), a1=7 -> busy for 33 cycles, then mult_hi=0xFFFFFFFF, mult_lo=0xFFFFFFEB.
REQ-034 SHALL: mult 0x80000000 x 0x80000000 -> mult_hi=0x40000000, mult_lo=0x00000000.
REQ-035 SHALL: hilo_read held from E0+1 after a mult -> stall high through E0+32, low at E0+33 with the new HI visible.
REQ-036 SHALL: mthi 0x12345678 followed by mult, then flush at E0+10 -> IDLE next cycle, mult_hi stays 0x12345678.
REQ-037 SHALL: rst=0 at E0+20 of a mult -> mult_hi=mult_lo=0, busy=0, req_ready=1 after release.

Source files
------------

// File: rtl/pipeline_latealu.sv
// Late-ALU unit: single-cycle srl/sra, mthi/mtlo, and a 33-cycle signed
// shift-add multiplier that owns the architectural HI/LO registers.
module pipeline_latealu (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_a1,
   input  logic        hilo_read,
   input  logic        flush,
   output logic        req_ready,
   output logic        stall,
   output logic        result_valid,
   output logic [31:0] result_value,
   output logic [31:0] mult_hi,
   output logic [31:0] mult_lo,
   output logic        busy,
   output logic        bad_op
);

   localparam logic [5:0] OP_SRL  = 6'b000010;
   localparam logic [5:0] OP_SRA  = 6'b000011;
   localparam logic [5:0] OP_MULT = 6'b000100;
   localparam logic [5:0] OP_MTHI = 6'b000101;
   localparam logic [5:0] OP_MTLO = 6'b000110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      FIX  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [32:0] mplier_q, mplier_d;
   logic        neg_q, neg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] res_q, res_d;
   logic        res_valid_q, res_valid_d;
   logic        bad_op_q, bad_op_d;

   logic        accept;
   logic [63:0] product;

   // Magnitude of a signed 32-bit value; 33 bits so that -2^31 is exact.
   function automatic logic [32:0] mag33(input logic [31:0] v);
      logic [32:0] ext;
      ext = {v[31], v};
      return v[31] ? (33'd0 - ext) : ext;
   endfunction

   assign accept = req_valid && (state_q == IDLE) && !flush;

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         neg_q       <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         bad_op_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         neg_q       <= neg_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         bad_op_q    <= bad_op_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept && (req_op == OP_MULT)) state_d = MULT;
         MULT: begin
            if (flush)                state_d = IDLE;
            else if (cnt_q == 6'd31)  state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      neg_d       = neg_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      res_d       = res_q;
      res_valid_d = 1'b0;
      bad_op_d    = 1'b0;
      product     = neg_q ? (64'd0 - acc_q) : acc_q;

      if (accept) begin
         unique case (req_op)
            OP_SRL: begin
               res_d       = req_a0 >> req_a1[4:0];
               res_valid_d = 1'b1;
            end
            OP_SRA: begin
               res_d       = $signed(req_a0) >>> req_a1[4:0];
               res_valid_d = 1'b1;
            end
            OP_MULT: begin
               acc_d    = '0;
               mcand_d  = {31'd0, mag33(req_a0)};
               mplier_d = mag33(req_a1);
               neg_d    = req_a0[31] ^ req_a1[31];
               cnt_d    = '0;
            end
            OP_MTHI: hi_d     = req_a0;
            OP_MTLO: lo_d     = req_a0;
            default: bad_op_d = 1'b1;
         endcase
      end

      if (flush && (state_q != IDLE)) begin
         cnt_d = '0;
      end else if (state_q == MULT) begin
         // One radix-2 step: add the shifted multiplicand when the current multiplier bit is set.
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
         mcand_d  = {mcand_q[62:0], 1'b0};
         mplier_d = {1'b0, mplier_q[32:1]};
         cnt_d    = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
      end else if (state_q == FIX) begin
         hi_d = product[63:32];
         lo_d = product[31:0];
      end
   end

   // Outputs
   always_comb begin
      req_ready    = (state_q == IDLE);
      busy         = (state_q != IDLE);
      stall        = (hilo_read && busy) || (req_valid && !req_ready);
      result_valid = res_valid_q;
      result_value = res_q;
      bad_op       = bad_op_q;
      mult_hi      = hi_q;
      mult_lo      = lo_q;
   end

endmodule

// File: tb/tb_pipeline_latealu.sv
// Directed bench for pipeline_latealu: shifts, HI/LO moves, mult timing,
// stall behaviour, flush and mid-operation reset.
module tb_pipeline_latealu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [5:0]  req_op;
   logic [31:0] req_a0;
   logic [31:0] req_a1;
   logic        hilo_read;
   logic        flush;
   logic        req_ready;
   logic        stall;
   logic        result_valid;
   logic [31:0] result_value;
   logic [31:0] mult_hi;
   logic [31:0] mult_lo;
   logic        busy;
   logic        bad_op;

   int checks   = 0;
   int failures = 0;

   localparam logic [5:0] OP_SRL  = 6'b000010;
   localparam logic [5:0] OP_SRA  = 6'b000011;
   localparam logic [5:0] OP_MULT = 6'b000100;
   localparam logic [5:0] OP_MTHI = 6'b000101;
   localparam logic [5:0] OP_MTLO = 6'b000110;

   pipeline_latealu dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
      .req_a0(req_a0), .req_a1(req_a1), .hilo_read(hilo_read), .flush(flush),
      .req_ready(req_ready), .stall(stall), .result_valid(result_valid),
      .result_value(result_value), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .busy(busy), .bad_op(bad_op)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1);
      req_valid = v;
      req_op    = op;
      req_a0    = a0;
      req_a1    = a1;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; hilo_read = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      tick(); tick();
      checks++; if (mult_hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", mult_hi, 32'd0); end
      checks++; if (mult_lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", mult_lo, 32'd0); end
      checks++; if ({result_valid, bad_op, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {result_valid, bad_op, busy}); end
      checks++; if (result_value !== 32'd0) begin failures++; $display("FAIL reset_value got=%h exp=%h", result_value, 32'd0); end
      rst = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_shift_pair();
      int not_ready = 0;
      drive(1'b1, OP_SRL, 32'h8000_0000, 32'd4);
      #1; if (req_ready !== 1'b1 || stall !== 1'b0) not_ready++;
      tick();
      checks++; if (result_valid !== 1'b1 || result_value !== 32'h0800_0000) begin failures++; $display("FAIL srl_pair got=%b/%h exp=1/08000000", result_valid, result_value); end
      drive(1'b1, OP_SRA, 32'h8000_0000, 32'd4);
      #1; if (req_ready !== 1'b1 || stall !== 1'b0) not_ready++;
      tick();
      checks++; if (result_valid !== 1'b1 || result_value !== 32'hF800_0000) begin failures++; $display("FAIL sra_pair got=%b/%h exp=1/f8000000", result_valid, result_value); end
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      tick();
      checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL shift_valid_drop got=%b exp=0", result_valid); end
      checks++; if (not_ready !== 0) begin failures++; $display("FAIL shift_ready got=%0d not-ready cycles exp=0", not_ready); end
   endtask

   task automatic test_shift_edges();
      logic [5:0]  ops  [6] = '{OP_SRL, OP_SRA, OP_SRL, OP_SRA, OP_SRA, OP_SRL};
      logic [31:0] a0s  [6] = '{32'hDEAD_BEEF, 32'h8765_4321, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFF0, 32'hF000_000F};
      logic [31:0] a1s  [6] = '{32'd0, 32'hFFFF_FFE0, 32'd31, 32'd31, 32'd4, 32'h0000_0024};
      logic [31:0] exps [6] = '{32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_0001, 32'hFFFF_FFFF, 32'h07FF_FFFF, 32'h0F00_0000};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, ops[i], a0s[i], a1s[i]);
         tick();
         checks++; if (result_valid !== 1'b1 || result_value !== exps[i]) begin failures++; $display("FAIL shift_vec%0d got=%b/%h exp=1/%h", i, result_valid, result_value, exps[i]); end
      end
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      tick();
   endtask

   task automatic test_mthi_mtlo();
      drive(1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      hilo_read = 1'b1;
      #1;
      checks++; if (stall !== 1'b0 || mult_hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi got=%b/%h exp=0/12345678", stall, mult_hi); end
      checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mthi_side got=%b/%b exp=0/0", result_valid, busy); end
      drive(1'b1, OP_MTLO, 32'hCAFE_0001, 32'd0);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      #1;
      checks++; if (mult_lo !== 32'hCAFE_0001 || mult_hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo got=%h/%h exp=12345678/cafe0001", mult_hi, mult_lo); end
      hilo_read = 1'b0;
      tick();
   endtask

   task automatic test_bad_op();
      drive(1'b1, 6'b111111, 32'hFFFF_FFFF, 32'd1);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      checks++; if (bad_op !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bad_op_pulse got=%b%b%b exp=100", bad_op, result_valid, busy); end
      checks++; if (mult_hi !== 32'h1234_5678 || mult_lo !== 32'hCAFE_0001) begin failures++; $display("FAIL bad_op_state got=%h/%h exp=12345678/cafe0001", mult_hi, mult_lo); end
      tick();
      checks++; if (bad_op !== 1'b0) begin failures++; $display("FAIL bad_op_drop got=%b exp=0", bad_op); end
   endtask

   task automatic test_mult(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] old_hi, old_lo;
      int cycles = 0;
      old_hi = mult_hi; old_lo = mult_lo;
      drive(1'b1, OP_MULT, a, b);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || mult_hi !== old_hi || mult_lo !== old_lo) begin failures++; $display("FAIL mult_start a=%h got busy=%b ready=%b hi/lo=%h/%h", a, busy, req_ready, mult_hi, mult_lo); end
      while (busy === 1'b1 && cycles < 100) begin
         if (cycles == 32 && (mult_hi !== old_hi || mult_lo !== old_lo)) begin
            checks++; failures++; $display("FAIL mult_early_write a=%h got=%h/%h exp=%h/%h", a, mult_hi, mult_lo, old_hi, old_lo);
         end
         tick();
         cycles++;
      end
      checks++; if (cycles !== 33) begin failures++; $display("FAIL mult_latency a=%h got=%0d exp=33", a, cycles); end
      checks++; if (mult_hi !== exp_hi || mult_lo !== exp_lo) begin failures++; $display("FAIL mult_result a=%h b=%h got=%h_%h exp=%h_%h", a, b, mult_hi, mult_lo, exp_hi, exp_lo); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mult_ready_after got=%b exp=1", req_ready); end
   endtask

   task automatic test_hilo_stall();
      int stalled = 0;
      hilo_read = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hilo_idle_stall got=%b exp=0", stall); end
      hilo_read = 1'b0;
      drive(1'b1, OP_MULT, 32'd5, 32'd6);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      hilo_read = 1'b1;
      for (int k = 0; k < 33; k++) begin
         #1; if (stall === 1'b1) stalled++;
         tick();
      end
      checks++; if (stalled !== 33) begin failures++; $display("FAIL hilo_stall_cycles got=%0d exp=33", stalled); end
      checks++; if (stall !== 1'b0 || mult_hi !== 32'd0 || mult_lo !== 32'd30) begin failures++; $display("FAIL hilo_release got=%b %h_%h exp=0 00000000_0000001e", stall, mult_hi, mult_lo); end
      hilo_read = 1'b0;
      tick();
   endtask

   task automatic test_busy_request();
      int cycles = 0;
      drive(1'b1, OP_MULT, 32'd2, 32'd3);
      tick();
      drive(1'b1, OP_SRL, 32'h0000_0100, 32'd8);
      #1;
      checks++; if (req_ready !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL busy_req_stall got ready=%b stall=%b exp 0/1", req_ready, stall); end
      tick(); tick();
      checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL busy_req_ignored got=%b exp=0", result_valid); end
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      while (busy === 1'b1 && cycles < 100) begin tick(); cycles++; end
      checks++; if (busy !== 1'b0 || mult_lo !== 32'd6 || mult_hi !== 32'd0) begin failures++; $display("FAIL busy_req_mult got=%b %h_%h exp=0 00000000_00000006", busy, mult_hi, mult_lo); end
   endtask

   task automatic test_flush();
      drive(1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
      tick();
      drive(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'd9);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL flush_idle got busy=%b ready=%b exp 0/1", busy, req_ready); end
      checks++; if (mult_hi !== 32'h1234_5678 || mult_lo !== 32'd6) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=12345678_00000006", mult_hi, mult_lo); end
      repeat (30) tick();
      checks++; if (mult_hi !== 32'h1234_5678 || mult_lo !== 32'd6) begin failures++; $display("FAIL flush_late_write got=%h_%h exp=12345678_00000006", mult_hi, mult_lo); end
      flush = 1'b1;
      drive(1'b1, OP_MTHI, 32'h0000_DEAD, 32'd0);
      tick();
      flush = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      checks++; if (mult_hi !== 32'h1234_5678) begin failures++; $display("FAIL flush_blocks_req got=%h exp=12345678", mult_hi); end
   endtask

   task automatic test_reset_mid_mult();
      drive(1'b1, OP_MULT, 32'd100, 32'd100);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      repeat (19) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (mult_hi !== 32'd0 || mult_lo !== 32'd0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=00000000_00000000", mult_hi, mult_lo); end
      checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_state got busy=%b ready=%b exp 0/1", busy, req_ready); end
      repeat (20) tick();
      checks++; if (mult_lo !== 32'd0) begin failures++; $display("FAIL rst_mid_late_write got=%h exp=00000000", mult_lo); end
      drive(1'b1, OP_SRL, 32'h0000_0100, 32'd8);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0);
      checks++; if (result_valid !== 1'b1 || result_value !== 32'd1) begin failures++; $display("FAIL rst_then_shift got=%b/%h exp=1/00000001", result_valid, result_value); end
   endtask

   initial begin
      test_reset();
      test_shift_pair();
      test_shift_edges();
      test_mthi_mtlo();
      test_bad_op();
      test_mult(32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB);
      test_mult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      test_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
      test_mult(32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
      test_mult(32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
      test_hilo_stall();
      test_busy_request();
      test_flush();
      test_reset_mid_mult();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
